// File: rtl/sd_pkg.sv
// Shared constants, FSM state type and CRC7 step for the SD command/response path.
package sd_pkg;

  localparam int         SD_FRAME_LEN   = 48;
  localparam int         SD_CRC_LEN     = 7;
  localparam int         SD_PAYLOAD_LEN = SD_FRAME_LEN - SD_CRC_LEN - 1;
  localparam logic [6:0] SD_CRC7_POLY   = 7'h09;
  localparam logic       SD_START_BIT   = 1'b0;
  localparam logic       SD_TX_BIT      = 1'b1;
  localparam logic       SD_END_BIT     = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_FINISH = 2'd3
  } sd_tx_state_e;

  // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first data.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_tx_if.sv
// Handshake and pad-side signals of the SD CMD-line transmitter.
interface sd_cmd_tx_if;

  logic        cmdStart;
  logic [5:0]  cmdIndex;
  logic [31:0] cmdArg;
  logic        busy;
  logic        done;
  logic        sdClk;
  logic        cmdOut;
  logic        cmdOe;

  modport master (
    output cmdStart, cmdIndex, cmdArg,
    input  busy, done, sdClk, cmdOut, cmdOe
  );

  modport slave (
    input  cmdStart, cmdIndex, cmdArg,
    output busy, done, sdClk, cmdOut, cmdOe
  );

endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; shared by the command transmitter and response receiver.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clkIn,
  input  logic       rstN,
  input  logic       clear,
  input  logic       enable,
  input  logic       dataIn,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = crc7_step(crc_q, dataIn);
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rstN) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_tx.sv
// SD CMD-line transmitter: free-running sdClk divider plus 48-bit frame serializer
// that launches each bit on an sdClk falling edge.
//
//   state  | meaning
//   IDLE   | waiting for cmdStart; frame latched on accept
//   ARMED  | busy, waiting for the next sdClk fall to drive the start bit
//   SHIFT  | one bit per sdClk fall: payload (into CRC), CRC7, end bit
//   FINISH | end bit held one more period; release pad and pulse done
module sd_cmd_tx
  import sd_pkg::*;
#(
  parameter int DIV = 100
)
(
  input logic        clkIn,
  input logic        rstN,
  sd_cmd_tx_if.slave bus
);

  localparam int              HALF         = DIV / 2;
  localparam int              CW           = $clog2(DIV);
  localparam int              MSB          = SD_PAYLOAD_LEN - 1;
  localparam logic [CW-1:0]   CNT_LAST     = CW'(DIV - 1);
  localparam logic [CW-1:0]   CNT_HALF     = CW'(HALF);
  localparam logic [CW-1:0]   CNT_PRE_FALL = CW'(HALF - 1);
  localparam logic [5:0]      BIT_FIRST    = 6'(SD_FRAME_LEN - 1);
  localparam logic [5:0]      BIT_CRC_TOP  = 6'(SD_CRC_LEN);

  if (DIV < 4 || (DIV % 2) != 0) begin : g_bad_div
    $error("sd_cmd_tx: DIV must be even and >= 4");
  end

  logic [CW-1:0] count_q, count_d;
  logic          sd_clk_q;
  logic          fall_tick;

  sd_tx_state_e              state_q, state_d;
  logic [SD_PAYLOAD_LEN-1:0] shift_q, shift_d;
  logic [5:0]                bit_cnt_q, bit_cnt_d;
  logic                      cmd_out_q, cmd_out_d;
  logic                      cmd_oe_q, cmd_oe_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic       crc_clear, crc_enable;
  logic [6:0] crc_val;
  logic [5:0] bit_next;
  logic [2:0] crc_idx;

  // Divider never stops, so the card clock stays continuous between frames.
  assign count_d   = (count_q == CNT_LAST) ? '0 : count_q + CW'(1);
  assign fall_tick = (count_q == CNT_PRE_FALL);

  always_ff @(posedge clkIn) begin
    if (!rstN) begin
      count_q  <= '0;
      sd_clk_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      sd_clk_q <= (count_d < CNT_HALF);
    end
  end

  assign bit_next = bit_cnt_q - 6'd1;
  assign crc_idx  = bit_next[2:0] - 3'd1;

  sd_crc7 u_crc7 (
    .clkIn  (clkIn),
    .rstN   (rstN),
    .clear  (crc_clear),
    .enable (crc_enable),
    .dataIn (shift_q[MSB]),
    .crc    (crc_val)
  );

  always_ff @(posedge clkIn) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.cmdStart) state_d = ST_ARMED;
      ST_ARMED:  if (fall_tick) state_d = ST_SHIFT;
      ST_SHIFT:  if (fall_tick && bit_next == '0) state_d = ST_FINISH;
      ST_FINISH: if (fall_tick) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    cmd_out_d  = cmd_out_q;
    cmd_oe_d   = cmd_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    crc_clear  = 1'b0;
    crc_enable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmdStart) begin
          shift_d   = {SD_START_BIT, SD_TX_BIT, bus.cmdIndex, bus.cmdArg};
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          crc_clear = 1'b1;
        end
      end
      ST_ARMED: begin
        if (fall_tick) begin
          cmd_oe_d   = 1'b1;
          cmd_out_d  = shift_q[MSB];
          shift_d    = {shift_q[MSB-1:0], 1'b0};
          bit_cnt_d  = BIT_FIRST;
          crc_enable = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (fall_tick) begin
          bit_cnt_d = bit_next;
          if (bit_next > BIT_CRC_TOP) begin
            cmd_out_d  = shift_q[MSB];
            shift_d    = {shift_q[MSB-1:0], 1'b0};
            crc_enable = 1'b1;
          end else if (bit_next != '0) begin
            // CRC is final once bit 8 has been folded in on the previous tick.
            cmd_out_d = crc_val[crc_idx];
          end else begin
            cmd_out_d = SD_END_BIT;
          end
        end
      end
      ST_FINISH: begin
        if (fall_tick) begin
          cmd_oe_d  = 1'b0;
          cmd_out_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (!rstN) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cmd_out_q <= 1'b1;
      cmd_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_out_q <= cmd_out_d;
      cmd_oe_q  <= cmd_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.sdClk  = sd_clk_q;
  assign bus.cmdOut = cmd_out_q;
  assign bus.cmdOe  = cmd_oe_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Bench for sd_cmd_tx: two instances (DIV=100 and DIV=4) checked against a frame model.
module tb_sd_cmd_tx;

  localparam int DIV_A = 100;
  localparam int DIV_B = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sd_cmd_tx_if if_a ();
  sd_cmd_tx_if if_b ();

  sd_cmd_tx #(.DIV(DIV_A)) dut_a (.clkIn(clk), .rstN(rst_n), .bus(if_a));
  sd_cmd_tx #(.DIV(DIV_B)) dut_b (.clkIn(clk), .rstN(rst_n), .bus(if_b));

  int sel = 0;
  wire m_oe    = (sel != 0) ? if_b.cmdOe  : if_a.cmdOe;
  wire m_out   = (sel != 0) ? if_b.cmdOut : if_a.cmdOut;
  wire m_busy  = (sel != 0) ? if_b.busy   : if_a.busy;
  wire m_done  = (sel != 0) ? if_b.done   : if_a.done;
  wire m_sdclk = (sel != 0) ? if_b.sdClk  : if_a.sdClk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          sel;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] frame;
    int          poke;
    bit          chain;
  } vec_t;

  vec_t tbl[5];

  function automatic void check(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endfunction

  // Frame model: CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [47:0] frame_of(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    logic [46:0] r;
    logic [46:0] g;
    m = {2'b01, idx, arg};
    r = {m, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) begin
        g = 47'h89 << (i - 7);
        r = r ^ g;
      end
    end
    return {m, r[6:0], 1'b1};
  endfunction

  task automatic drive_start(input logic [5:0] idx, input logic [31:0] arg);
    if (sel != 0) begin
      if_b.cmdStart = 1'b1; if_b.cmdIndex = idx; if_b.cmdArg = arg;
    end else begin
      if_a.cmdStart = 1'b1; if_a.cmdIndex = idx; if_a.cmdArg = arg;
    end
  endtask

  task automatic drive_idle();
    if_a.cmdStart = 1'b0;
    if_b.cmdStart = 1'b0;
  endtask

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input string tag);
    drive_start(idx, arg);
    @(negedge clk);
    drive_idle();
    check(m_busy && !m_done && !m_oe, {tag, " accept"}, {m_busy, m_done, m_oe}, 3'b100);
  endtask

  // Called on the first sample after an accepted start.
  task automatic check_frame(input int div, input logic [47:0] exp_frame, input int exp_lat,
                             input int poke_bit, input string tag);
    int lat, bad_bit, bad_clk, dones, b;
    bit armed_ok;
    logic [47:0] got;
    lat = 0;
    armed_ok = 1'b1;
    while (!m_oe && lat <= div + 1) begin
      if (!m_busy || m_done) armed_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check(armed_ok, {tag, " armed_busy"}, armed_ok, 1);
    if (!m_oe) begin
      check(1'b0, {tag, " first_bit_timeout"}, lat, div);
      return;
    end
    if (exp_lat < 0) check(lat >= 1 && lat <= div, {tag, " latency"}, lat, div);
    else             check(lat == exp_lat, {tag, " latency"}, lat, exp_lat);
    bad_bit = 0; bad_clk = 0; dones = 0; got = '0;
    for (int k = 0; k < 48 * div; k++) begin
      b = 47 - k / div;
      if (m_out !== exp_frame[b] || m_oe !== 1'b1 || m_busy !== 1'b1) bad_bit++;
      if (m_sdclk !== ((k % div) >= div / 2)) bad_clk++;
      if (m_done) dones++;
      if (k % div == div / 2) got[b] = m_out;
      if (poke_bit >= 0 && k == (47 - poke_bit) * div + 1) drive_start(6'h3F, 32'hFFFF_FFFF);
      if (poke_bit >= 0 && k == (47 - poke_bit) * div + 2) drive_idle();
      @(negedge clk);
    end
    check(got == exp_frame, {tag, " frame"}, got, exp_frame);
    check(bad_bit == 0, {tag, " bit_hold_errors"}, bad_bit, 0);
    check(bad_clk == 0, {tag, " sdclk_shape_errors"}, bad_clk, 0);
    check(dones == 0, {tag, " early_done"}, dones, 0);
    check({m_done, m_oe, m_out, m_busy} == 4'b1010, {tag, " done_edge"},
          {m_done, m_oe, m_out, m_busy}, 4'b1010);
  endtask

  initial begin
    bit prev;
    int lat, dones, p, exp_lat, tmo, bad;
    logic [5:0] ridx;
    logic [31:0] rarg;

    drive_idle();
    if_a.cmdIndex = '0; if_a.cmdArg = '0;
    if_b.cmdIndex = '0; if_b.cmdArg = '0;

    tbl[0] = '{0, 6'd0,  32'h0000_0000, 48'h40_0000_0000_95, 10, 1'b0};
    tbl[1] = '{0, 6'd17, 32'h0000_0000, 48'h51_0000_0000_55, -1, 1'b1};
    tbl[2] = '{1, 6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87, -1, 1'b0};
    tbl[3] = '{1, 6'd55, 32'h0000_0000, frame_of(6'd55, 32'h0), -1, 1'b0};
    tbl[4] = '{1, 6'd41, 32'h40FF_8000, frame_of(6'd41, 32'h40FF_8000), -1, 1'b1};

    repeat (3) @(negedge clk);
    sel = 0;
    check({m_oe, m_out, m_busy, m_sdclk, m_done} == 5'b01010, "reset_state_a",
          {m_oe, m_out, m_busy, m_sdclk, m_done}, 5'b01010);
    sel = 1;
    check({m_oe, m_out, m_busy, m_sdclk, m_done} == 5'b01010, "reset_state_b",
          {m_oe, m_out, m_busy, m_sdclk, m_done}, 5'b01010);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      sel = tbl[i].sel;
      if (!tbl[i].chain) begin
        @(negedge clk);
        check(!m_done, $sformatf("vec%0d done_single", i), m_done, 0);
        repeat (2) @(negedge clk);
      end
      start_cmd(tbl[i].idx, tbl[i].arg, $sformatf("vec%0d", i));
      check_frame(sel != 0 ? DIV_B : DIV_A, tbl[i].frame, -1, tbl[i].poke,
                  $sformatf("vec%0d", i));
    end

    // Start at every divider phase of the DIV=4 instance.
    sel = 1;
    @(negedge clk);
    for (p = 0; p < DIV_B; p++) begin
      tmo = 0;
      prev = m_sdclk;
      @(negedge clk);
      while (!(prev && !m_sdclk) && tmo < 2 * DIV_B) begin
        prev = m_sdclk;
        @(negedge clk);
        tmo++;
      end
      check(tmo < 2 * DIV_B, $sformatf("phase%0d sdclk_fall_seen", p), tmo, 2 * DIV_B);
      repeat (p) @(negedge clk);
      exp_lat = DIV_B - 1 - p;
      if (exp_lat == 0) exp_lat = DIV_B;
      ridx = 6'($urandom_range(0, 63));
      rarg = $urandom;
      start_cmd(ridx, rarg, $sformatf("phase%0d", p));
      check_frame(DIV_B, frame_of(ridx, rarg), exp_lat, -1, $sformatf("phase%0d", p));
    end

    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
      ridx = 6'($urandom_range(0, 63));
      rarg = $urandom;
      start_cmd(ridx, rarg, $sformatf("rand%0d", i));
      check_frame(DIV_B, frame_of(ridx, rarg), -1, -1, $sformatf("rand%0d", i));
    end

    // Reset while bit 20 is on the line.
    sel = 0;
    repeat (2) @(negedge clk);
    start_cmd(6'd2, 32'h1234_5678, "rst");
    lat = 0;
    while (!m_oe && lat <= DIV_A + 1) begin
      @(negedge clk);
      lat++;
    end
    check(m_oe, "rst first_bit_seen", m_oe, 1);
    dones = 0;
    for (int k = 0; k < 27 * DIV_A + DIV_A / 2; k++) begin
      if (m_done) dones++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check({m_oe, m_out, m_busy, m_sdclk, m_done} == 5'b01010, "rst abort_state",
          {m_oe, m_out, m_busy, m_sdclk, m_done}, 5'b01010);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 3 * DIV_A; k++) begin
      if (m_done) dones++;
      if (m_oe || m_busy) bad++;
      @(negedge clk);
    end
    check(dones == 0, "rst no_done", dones, 0);
    check(bad == 0, "rst stays_idle", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
